// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester arbiter for one BRAM port with burst lock and tagged read return
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   req0/1, we0/1, addr0/1,      per-requester beat request (read when we=0)
//   wdata0/1
//   gnt0/1                       beat of requester i issued to the BRAM this cycle
//   rvalid0/1, rdata0/1          read data return, steered by the tag of the issuing requester
//   bram_en/we/addr/din          BRAM A-port command, zero when no beat is issued
//   bram_dout                    BRAM read data, READ_LAT cycles after a read beat
//
// Build option: SVM_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins in IDLE
// and preempts OWN1); left undefined gives round-robin with burst lock.

module bram_port_arbiter #(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WIDTH-1:0]  bram_din,
    input  logic [WIDTH-1:0]  bram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t             state;
    logic               last_owner;
    logic [CNT_W-1:0]   beat_cnt;
    logic [READ_LAT-1:0] pipe_v;
    logic [READ_LAT-1:0] pipe_id;

    logic burst_done;
    logic idle_pick0;
    logic own1_yield;

    assign gnt0 = (state == OWN0) & req0;
    assign gnt1 = (state == OWN1) & req1;

    assign bram_en   = gnt0 | gnt1;
    assign bram_we   = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
    assign bram_addr = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
    assign bram_din  = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

    // Returns follow the tag captured at issue time, not the current owner.
    assign rvalid0 = pipe_v[READ_LAT-1] & ~pipe_id[READ_LAT-1];
    assign rvalid1 = pipe_v[READ_LAT-1] &  pipe_id[READ_LAT-1];
    assign rdata0  = bram_dout;
    assign rdata1  = bram_dout;

    assign burst_done = (beat_cnt == CNT_LAST);

`ifdef SVM_ARB_FIXED_PRIO_EN
    assign idle_pick0 = req0;
    assign own1_yield = req0;
`else
    // last_owner==1 means requester 0 gets the next contested arbitration.
    assign idle_pick0 = req0 & (~req1 | last_owner);
    assign own1_yield = burst_done & req0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (idle_pick0) begin
                        state <= OWN0;
                    end else if (req1) begin
                        state <= OWN1;
                    end
                end
                OWN0: begin
                    if (!req0) begin
                        state      <= req1 ? OWN1 : IDLE;
                        last_owner <= 1'b0;
                        beat_cnt   <= '0;
                    end else if (burst_done && req1) begin
                        state      <= OWN1;
                        last_owner <= 1'b0;
                        beat_cnt   <= '0;
                    end else if (!burst_done) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                OWN1: begin
                    if (!req1) begin
                        state      <= req0 ? OWN0 : IDLE;
                        last_owner <= 1'b1;
                        beat_cnt   <= '0;
                    end else if (own1_yield) begin
                        state      <= OWN0;
                        last_owner <= 1'b1;
                        beat_cnt   <= '0;
                    end else if (!burst_done) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // Read-return tag pipe; flushed by reset so in-flight reads never return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v[0]  <= (gnt0 & ~we0) | (gnt1 & ~we1);
            pipe_id[0] <= gnt1;
            for (int k = 1; k < READ_LAT; k++) begin
                pipe_v[k]  <= pipe_v[k-1];
                pipe_id[k] <= pipe_id[k-1];
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - self-checking bench for bram_port_arbiter, READ_LAT 1 and 2 instances side by side

module tb_bram_port_arbiter;

    localparam int WIDTH     = 16;
    localparam int ADDR_W    = 10;
    localparam int MAX_BURST = 16;
`ifdef SVM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic rst;
    logic req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [WIDTH-1:0]  wdata0, wdata1;

    // Outputs of both instances packed side by side; index g = READ_LAT-1.
    logic [1:0]          gnt0_a, gnt1_a, rv0_a, rv1_a, en_a, we_a;
    logic [2*ADDR_W-1:0] addr_a;
    logic [2*WIDTH-1:0]  din_a, rd0_a, rd1_a;

    for (genvar g = 0; g < 2; g++) begin : gi
        logic              gnt0_l, gnt1_l, rv0_l, rv1_l, en_l, we_l;
        logic [ADDR_W-1:0] addr_l;
        logic [WIDTH-1:0]  din_l, rd0_l, rd1_l, dout_l;
        logic [WIDTH-1:0]  mem [1024];
        logic [WIDTH-1:0]  q1, q2;

        initial begin
            for (int k = 0; k < 1024; k++) mem[k] = WIDTH'(k + 'h100);
            q1 = '0;
            q2 = '0;
        end

        // Read-first BRAM model with selectable latency.
        always @(posedge clk) begin
            if (en_l) begin
                q1 <= mem[addr_l];
                if (we_l) mem[addr_l] <= din_l;
            end
            q2 <= q1;
        end
        assign dout_l = (g == 0) ? q1 : q2;

        bram_port_arbiter #(
            .WIDTH(WIDTH), .ADDR_W(ADDR_W), .READ_LAT(g + 1), .MAX_BURST(MAX_BURST)
        ) dut (
            .clk(clk), .reset(rst),
            .req0(req0), .req1(req1), .we0(we0), .we1(we1),
            .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
            .gnt0(gnt0_l), .gnt1(gnt1_l),
            .rvalid0(rv0_l), .rvalid1(rv1_l), .rdata0(rd0_l), .rdata1(rd1_l),
            .bram_en(en_l), .bram_we(we_l), .bram_addr(addr_l), .bram_din(din_l),
            .bram_dout(dout_l)
        );

        assign gnt0_a[g] = gnt0_l;
        assign gnt1_a[g] = gnt1_l;
        assign rv0_a[g]  = rv0_l;
        assign rv1_a[g]  = rv1_l;
        assign en_a[g]   = en_l;
        assign we_a[g]   = we_l;
        assign addr_a[g*ADDR_W +: ADDR_W] = addr_l;
        assign din_a[g*WIDTH +: WIDTH]    = din_l;
        assign rd0_a[g*WIDTH +: WIDTH]    = rd0_l;
        assign rd1_a[g*WIDTH +: WIDTH]    = rd1_l;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Requester queues: {we, addr, data}
    logic [WIDTH+ADDR_W:0] q0[$], q1[$];
    bit hit0, hit1;

    initial begin
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        forever begin
            @(posedge clk); #1;
            if (hit0 && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                req0 = 1'b1;
                {we0, addr0, wdata0} = q0[0];
            end else begin
                req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
            end
        end
    end

    initial begin
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        forever begin
            @(posedge clk); #1;
            if (hit1 && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                req1 = 1'b1;
                {we1, addr1, wdata1} = q1[0];
            end else begin
                req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
            end
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int              cyc;
        logic            id;
        logic [WIDTH-1:0] d;
    } rd_t;

    rd_t              sched[$];
    logic [WIDTH-1:0] mmem [1024];
    int               m_own;    // -1 nobody, 0/1 owner
    int               m_last;
    int               m_beats;  // beats granted in the current tenure
    int               cyc = 0;
    bit               tr_on = 0;
    int               trace[$];
    logic [WIDTH:0]   log_a[$], log_b[$];

    initial begin
        for (int k = 0; k < 1024; k++) mmem[k] = WIDTH'(k + 'h100);
        m_own = -1; m_last = 1; m_beats = 0;
    end

    always @(negedge clk) begin : cmp
        logic e0, e1, ew, ev0, ev1, ri, rj;
        logic [ADDR_W-1:0] ea;
        logic [WIDTH-1:0]  ed, rdv;
        cyc++;
        hit0 = gnt0_a[0];
        hit1 = gnt1_a[0];
        if (rst) begin
            m_own = -1; m_last = 1; m_beats = 0;
            sched.delete();
            for (int g = 0; g < 2; g++) begin
                chk("rst_gnt0", 32'(gnt0_a[g]), 0);
                chk("rst_gnt1", 32'(gnt1_a[g]), 0);
                chk("rst_rvalid", 32'({rv1_a[g], rv0_a[g]}), 0);
                chk("rst_bram_cmd", 32'({en_a[g], we_a[g], addr_a[g*ADDR_W +: ADDR_W]}), 0);
                chk("rst_bram_din", 32'(din_a[g*WIDTH +: WIDTH]), 0);
            end
        end else begin
            e0 = (m_own == 0) && req0;
            e1 = (m_own == 1) && req1;
            ew = e0 ? we0 : (e1 ? we1 : 1'b0);
            ea = e0 ? addr0 : (e1 ? addr1 : '0);
            ed = e0 ? wdata0 : (e1 ? wdata1 : '0);
            for (int g = 0; g < 2; g++) begin
                chk("gnt0", 32'(gnt0_a[g]), 32'(e0));
                chk("gnt1", 32'(gnt1_a[g]), 32'(e1));
                chk("bram_en", 32'(en_a[g]), 32'(e0 | e1));
                chk("bram_we", 32'(we_a[g]), 32'(ew));
                chk("bram_addr", 32'(addr_a[g*ADDR_W +: ADDR_W]), 32'(ea));
                chk("bram_din", 32'(din_a[g*WIDTH +: WIDTH]), 32'(ed));
                ev0 = 0; ev1 = 0; rdv = '0;
                foreach (sched[i]) begin
                    if (sched[i].cyc + g + 1 == cyc) begin
                        if (sched[i].id) ev1 = 1; else ev0 = 1;
                        rdv = sched[i].d;
                    end
                end
                chk("rvalid0", 32'(rv0_a[g]), 32'(ev0));
                chk("rvalid1", 32'(rv1_a[g]), 32'(ev1));
                if (ev0) chk("rdata0", 32'(rd0_a[g*WIDTH +: WIDTH]), 32'(rdv));
                if (ev1) chk("rdata1", 32'(rd1_a[g*WIDTH +: WIDTH]), 32'(rdv));
                if (rv0_a[g] || rv1_a[g]) begin
                    if (g == 0) log_a.push_back({rv1_a[g], rv1_a[g] ? rd1_a[g*WIDTH +: WIDTH] : rd0_a[g*WIDTH +: WIDTH]});
                    else        log_b.push_back({rv1_a[g], rv1_a[g] ? rd1_a[g*WIDTH +: WIDTH] : rd0_a[g*WIDTH +: WIDTH]});
                end
            end
            while (sched.size() > 0 && sched[0].cyc + 2 <= cyc) void'(sched.pop_front());
            if (e0 || e1) begin
                if (ew) mmem[ea] = ed;
                else sched.push_back('{cyc, e1, mmem[ea]});
            end
            if (tr_on) trace.push_back(e0 ? 0 : (e1 ? 1 : -1));
            // ownership rules
            if (m_own < 0) begin
                m_beats = 0;
                if (req0 && req1) m_own = (FIXED || m_last == 1) ? 0 : 1;
                else if (req0) m_own = 0;
                else if (req1) m_own = 1;
            end else begin
                ri = (m_own == 0) ? req0 : req1;
                rj = (m_own == 0) ? req1 : req0;
                if (!ri) begin
                    m_last  = m_own;
                    m_own   = rj ? 1 - m_own : -1;
                    m_beats = 0;
                end else begin
                    m_beats++;
                    if (rj && (m_beats >= MAX_BURST || (FIXED && m_own == 1))) begin
                        m_last  = m_own;
                        m_own   = 1 - m_own;
                        m_beats = 0;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_idle(input string nm);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, 32'(n >= 300), 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_hit(input int side, input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(side == 0 ? hit0 : hit1) && n < 100);
        chk({nm, "_timeout"}, 32'(n >= 100), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic start_trace();
        trace.delete();
        log_a.delete();
        log_b.delete();
        tr_on = 1'b1;
    endtask

    initial begin : main
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: req0 reads 0..3 alone
        @(posedge clk);
        start_trace();
        for (int k = 0; k < 4; k++) q0.push_back({1'b0, ADDR_W'(k), 16'h0});
        wait_idle("t1");
        tr_on = 1'b0;
        chk("t1_arb_idle", trace[0], -1);
        for (int k = 1; k <= 4; k++) chk("t1_gnt0_seq", trace[k], 0);
        chk("t1_nlog", 32'(log_a.size() + log_b.size()), 8);
        for (int k = 0; k < 4 && k < log_a.size() && k < log_b.size(); k++) begin
            chk("t1_rdata_lat1", 32'(log_a[k]), 32'('h100 + k));
            chk("t1_rdata_lat2", 32'(log_b[k]), 32'('h100 + k));
        end

        // 2: both raised after reset, burst lock at 16 beats
        pulse_reset();
        @(posedge clk);
        start_trace();
        for (int k = 0; k < 20; k++) q0.push_back({1'b0, ADDR_W'(k + 16), 16'h0});
        for (int k = 0; k < 3; k++)  q1.push_back({1'b1, ADDR_W'('h200 + k), WIDTH'('hA000 + k)});
        wait_idle("t2");
        tr_on = 1'b0;
        chk("t2_arb_idle", trace[0], -1);
        n = 0;
        for (int k = 1; k <= 16; k++) if (trace[k] == 0) n++;
        chk("t2_gnt0_burst", n, 16);
        chk("t2_handover_no_bubble", trace[17], 1);

        // 3: req1 writes mem[5], req0 reads it back
        @(posedge clk);
        start_trace();
        q1.push_back({1'b1, ADDR_W'(5), 16'hBEEF});
        wait_idle("t3w");
        q0.push_back({1'b0, ADDR_W'(5), 16'h0});
        wait_idle("t3r");
        tr_on = 1'b0;
        chk("t3_nlog", 32'(log_a.size()), 1);
        if (log_a.size() > 0) chk("t3_rdata0_lat1", 32'(log_a[0]), 32'h0BEEF);
        if (log_b.size() > 0) chk("t3_rdata0_lat2", 32'(log_b[0]), 32'h0BEEF);

        // 4: read at 7 then hand-over to req1 while the read is in flight
        @(posedge clk);
        start_trace();
        q0.push_back({1'b0, ADDR_W'(7), 16'h0});
        wait_hit(0, "t4_gnt0", n);
        q1.push_back({1'b0, ADDR_W'(9), 16'h0});
        wait_idle("t4");
        tr_on = 1'b0;
        chk("t4_nlog", 32'(log_a.size() + log_b.size()), 4);
        if (log_a.size() == 2 && log_b.size() == 2) begin
            chk("t4_tag0_lat1", 32'(log_a[0]), 32'h00107);
            chk("t4_tag1_lat1", 32'(log_a[1]), 32'h10109);
            chk("t4_tag0_lat2", 32'(log_b[0]), 32'h00107);
            chk("t4_tag1_lat2", 32'(log_b[1]), 32'h10109);
        end

        // 5: reset one cycle after a read grant flushes the return
        @(posedge clk);
        start_trace();
        q0.push_back({1'b0, ADDR_W'(3), 16'h0});
        wait_hit(0, "t5_gnt0", n);
        pulse_reset();
        repeat (4) @(negedge clk);
        chk("t5_no_rvalid", 32'(log_a.size() + log_b.size()), 0);
        @(posedge clk);
        trace.delete();
        q0.push_back({1'b0, ADDR_W'(1), 16'h0});
        q1.push_back({1'b0, ADDR_W'(2), 16'h0});
        wait_idle("t5");
        tr_on = 1'b0;
        chk("t5_idle_after_reset", trace[0], -1);
        chk("t5_req0_first", trace[1], 0);

`ifdef SVM_ARB_FIXED_PRIO_EN
        // 6: req0 preempts a req1 burst on the next cycle
        @(posedge clk);
        for (int k = 0; k < 6; k++) q1.push_back({1'b1, ADDR_W'('h300 + k), WIDTH'('hC000 + k)});
        wait_hit(1, "t6_gnt1", n);
        q0.push_back({1'b0, ADDR_W'(4), 16'h0});
        wait_hit(0, "t6_gnt0", n);
        chk("t6_preempt_latency", n, 2);
        wait_idle("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
